// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU for the execute stage.
//   Accepts one op per cycle over valid/ready. Each op carries an opaque tag that is
//   returned unchanged with its result. The result is computed on entry and
//   registered into stage 0. Stages 1..STAGES-1 only move data toward the output.
// Ports:
//   i_clk, i_rst_n      clock; synchronous active-low reset
//   i_valid/o_ready     input handshake for i_op, i_src1, i_src2, i_tag
//   i_flush             drops every in-flight op and any input offered in the same cycle
//   o_valid/i_ready     output handshake for o_dest, o_tag
//   o_count             number of valid stages (ops in flight)

// One pipeline register: a valid bit plus an opaque payload.
module alu_pipe_stage #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_load,   // upstream hands over a new payload this cycle
    input  logic         i_adv,    // this stage's payload leaves this cycle
    input  logic [W-1:0] i_data,
    output logic         o_vld,
    output logic [W-1:0] o_data
);
    // A load has priority over an advance, so advance plus replace keeps the stage
    // valid. The payload only changes on load, so a stalled stage holds steady.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_vld  <= 1'b0;
            o_data <= '0;
        end else if (i_flush) begin
            o_vld  <= 1'b0;
        end else if (i_load) begin
            o_vld  <= 1'b1;
            o_data <= i_data;
        end else if (i_adv) begin
            o_vld  <= 1'b0;
        end
    end
endmodule

module alu_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 6,
    parameter int STAGES     = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [3:0]                  i_op,
    input  logic [DATA_WIDTH-1:0]       i_src1,
    input  logic [DATA_WIDTH-1:0]       i_src2,
    input  logic [TAG_WIDTH-1:0]        i_tag,
    input  logic                        i_flush,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [DATA_WIDTH-1:0]       o_dest,
    output logic [TAG_WIDTH-1:0]        o_tag,
    output logic [$clog2(STAGES+1)-1:0] o_count
);
    localparam int SH_W  = $clog2(DATA_WIDTH);
    localparam int CNT_W = $clog2(STAGES+1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dest;
        logic [TAG_WIDTH-1:0]  tag;
    } res_t;
    localparam int RES_W = $bits(res_t);

    // vld_pipe[0] is the input transfer of this cycle; vld_pipe[k+1] is stage k's valid.
    // res_pipe follows the same indexing: [0] is the freshly computed result.
    logic [STAGES:0]   vld_pipe;
    res_t [STAGES:0]   res_pipe;
    logic [STAGES-1:0] adv;
    logic [SH_W-1:0]   sh;
    res_t              res_in;

    assign sh = i_src2[SH_W-1:0];

    always_comb begin
        res_in      = '0;
        res_in.tag  = i_tag;
        case (i_op)
            OP_ADD:  res_in.dest = i_src1 + i_src2;
            OP_SUB:  res_in.dest = i_src1 - i_src2;
            OP_AND:  res_in.dest = i_src1 & i_src2;
            OP_OR:   res_in.dest = i_src1 | i_src2;
            OP_XOR:  res_in.dest = i_src1 ^ i_src2;
            OP_SLL:  res_in.dest = i_src1 << sh;
            OP_SRL:  res_in.dest = i_src1 >> sh;
            OP_SRA:  res_in.dest = $unsigned($signed(i_src1) >>> sh);
            OP_SLT:  res_in.dest[0] = $signed(i_src1) < $signed(i_src2);
            OP_SLTU: res_in.dest[0] = i_src1 < i_src2;
            default: res_in.dest = '0;   // unused opcodes still retire with their tag
        endcase
    end

    // Advance chain runs from the output back toward the input, so a bubble anywhere
    // lets everything behind it move up in the same cycle.
    assign adv[STAGES-1] = vld_pipe[STAGES] & i_ready;
    for (genvar k = 0; k < STAGES-1; k++) begin : g_adv
        assign adv[k] = vld_pipe[k+1] & (~vld_pipe[k+2] | adv[k+1]);
    end

    assign o_ready     = ~vld_pipe[1] | adv[0];
    // A flushed input is never loaded; the flush also overrides every stage below.
    assign vld_pipe[0] = i_valid & o_ready & ~i_flush;
    assign res_pipe[0] = res_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic ld;
        if (k == 0) begin : g_first
            assign ld = vld_pipe[0];
        end else begin : g_rest
            assign ld = adv[k-1];
        end
        alu_pipe_stage #(.W(RES_W)) u_stg (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_flush (i_flush),
            .i_load  (ld),
            .i_adv   (adv[k]),
            .i_data  (res_pipe[k]),
            .o_vld   (vld_pipe[k+1]),
            .o_data  (res_pipe[k+1])
        );
    end

    assign o_valid = vld_pipe[STAGES];
    assign o_dest  = res_pipe[STAGES].dest;
    assign o_tag   = res_pipe[STAGES].tag;

    // Occupancy is derived from the valid bits themselves, so it can never drift.
    always_comb begin
        o_count = '0;
        for (int k = 0; k < STAGES; k++) begin
            o_count = o_count + CNT_W'(vld_pipe[k+1]);
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        rst_n [3];
    logic        vin   [3];
    logic        rin   [3];
    logic        fl    [3];
    logic        ordy  [3];
    logic        oval  [3];
    logic [3:0]  op    [3];
    logic [63:0] s1    [3];
    logic [63:0] s2    [3];
    logic [63:0] dst   [3];
    logic [5:0]  tgi   [3];
    logic [5:0]  tgo   [3];
    logic [2:0]  cnt   [3];

    typedef struct packed {
        logic [63:0] d;
        logic [5:0]  t;
    } exp_t;

    function automatic int stg(int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    // Reference ALU written directly from the opcode table.
    function automatic logic [63:0] ref_alu(logic [3:0] o, logic [63:0] a, logic [63:0] b);
        int sh;
        logic [127:0] ext;
        sh = int'(b[5:0]);
        case (o)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: begin
                ext = {{64{a[63]}}, a};
                ext = ext >> sh;
                return ext[63:0];
            end
            4'd8: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd9: return (a < b) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gd
        localparam int S  = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        localparam int CW = $clog2(S+1);
        logic [CW-1:0] c;
        exp_t q[$];
        bit armed = 1'b0;

        alu_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(6), .STAGES(S)) dut (
            .i_clk   (clk),
            .i_rst_n (rst_n[g]),
            .i_valid (vin[g]),
            .o_ready (ordy[g]),
            .i_op    (op[g]),
            .i_src1  (s1[g]),
            .i_src2  (s2[g]),
            .i_tag   (tgi[g]),
            .i_flush (fl[g]),
            .o_valid (oval[g]),
            .i_ready (rin[g]),
            .o_dest  (dst[g]),
            .o_tag   (tgo[g]),
            .o_count (c)
        );
        assign cnt[g] = 3'(c);

        // Scoreboard: every accepted op waits in order until its output handshake.
        initial forever begin
            @(negedge clk);
            if (!rst_n[g]) begin
                armed = 1'b1;
                q.delete();
            end else if (armed) begin
                if (fl[g]) begin
                    q.delete();
                end else begin
                    check($sformatf("s%0d count", S), 64'(cnt[g]), 64'(q.size()));
                    check($sformatf("s%0d o_ready", S), 64'(ordy[g]),
                          (q.size() < S || rin[g]) ? 64'd1 : 64'd0);
                    if (oval[g]) begin
                        if (q.size() == 0) begin
                            check($sformatf("s%0d spurious_valid", S), 64'd1, 64'd0);
                        end else begin
                            check($sformatf("s%0d dest", S), dst[g], q[0].d);
                            check($sformatf("s%0d tag", S), 64'(tgo[g]), 64'(q[0].t));
                            if (rin[g]) void'(q.pop_front());
                        end
                    end
                    if (vin[g] && ordy[g])
                        q.push_back('{ref_alu(op[g], s1[g], s2[g]), tgi[g]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int d);
        vin[d] = 1'b0; rin[d] = 1'b1; fl[d] = 1'b0;
        op[d] = 4'd0; s1[d] = 64'd0; s2[d] = 64'd0; tgi[d] = 6'd0;
    endtask

    task automatic chk_reset_state(int d, string nm);
        @(negedge clk);
        check({nm, " o_valid"}, 64'(oval[d]), 64'd0);
        check({nm, " o_dest"},  dst[d], 64'd0);
        check({nm, " o_tag"},   64'(tgo[d]), 64'd0);
        check({nm, " o_count"}, 64'(cnt[d]), 64'd0);
        check({nm, " o_ready"}, 64'(ordy[d]), 64'd1);
        tick();
    endtask

    // Offer one op and hold it until accepted (bounded).
    task automatic send(int d, logic [3:0] o, logic [63:0] a, logic [63:0] b, logic [5:0] t);
        bit acc;
        int w;
        acc = 1'b0; w = 0;
        vin[d] = 1'b1; op[d] = o; s1[d] = a; s2[d] = b; tgi[d] = t;
        while (!acc && w < 200) begin
            @(negedge clk);
            acc = ordy[d];
            tick();
            w++;
        end
        if (!acc) check($sformatf("s%0d send_timeout", stg(d)), 64'd0, 64'd1);
        vin[d] = 1'b0;
    endtask

    // Single op into an empty pipe with the consumer always ready.
    task automatic directed(int d, string nm, logic [3:0] o, logic [63:0] a, logic [63:0] b,
                            logic [5:0] t, logic [63:0] e);
        int n;
        vin[d] = 1'b1; op[d] = o; s1[d] = a; s2[d] = b; tgi[d] = t; rin[d] = 1'b1;
        @(negedge clk);
        check({nm, " accept"}, 64'(ordy[d]), 64'd1);
        tick();
        vin[d] = 1'b0;
        n = 1;
        @(negedge clk);
        while (!oval[d] && n < 20) begin
            tick();
            n++;
            @(negedge clk);
        end
        check({nm, " latency"}, 64'(n), 64'(stg(d)));
        check({nm, " dest"}, dst[d], e);
        check({nm, " tag"}, 64'(tgo[d]), 64'(t));
        tick();
    endtask

    task automatic stream10(int d);
        int got[$];
        fork
            begin
                for (int t = 0; t < 10; t++)
                    send(d, 4'($urandom_range(0, 15)), {$urandom, $urandom},
                         {$urandom, $urandom}, 6'(t));
            end
            begin
                for (int k = 0; k < 400 && got.size() < 10; k++) begin
                    rin[d] = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (oval[d] && rin[d]) got.push_back(int'(tgo[d]));
                    tick();
                end
                rin[d] = 1'b1;
            end
        join
        check($sformatf("s%0d stream_n", stg(d)), 64'(got.size()), 64'd10);
        for (int i = 0; i < got.size(); i++)
            check($sformatf("s%0d stream_order%0d", stg(d), i), 64'(got[i]), 64'(i));
    endtask

    task automatic flush_test(int d);
        int seen;
        rin[d] = 1'b0;
        send(d, 4'd0, 64'd1, 64'd2, 6'd40);
        send(d, 4'd1, 64'd9, 64'd3, 6'd41);
        vin[d] = 1'b1; op[d] = 4'd4; s1[d] = 64'd5; s2[d] = 64'd6; tgi[d] = 6'd42; fl[d] = 1'b1;
        tick();
        vin[d] = 1'b0; fl[d] = 1'b0;
        @(negedge clk);
        check($sformatf("s%0d flush_count", stg(d)), 64'(cnt[d]), 64'd0);
        check($sformatf("s%0d flush_valid", stg(d)), 64'(oval[d]), 64'd0);
        tick();
        rin[d] = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (oval[d]) seen++;
            tick();
        end
        check($sformatf("s%0d flush_no_output", stg(d)), 64'(seen), 64'd0);
    endtask

    task automatic soak(int d);
        for (int k = 0; k < 300; k++) begin
            vin[d] = ($urandom_range(0, 3) != 0);
            rin[d] = 1'($urandom_range(0, 1));
            fl[d]  = ($urandom_range(0, 39) == 0);
            op[d]  = 4'($urandom_range(0, 15));
            s1[d]  = {$urandom, $urandom};
            s2[d]  = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 127));
            tgi[d] = 6'($urandom);
            tick();
        end
        idle(d);
        repeat (10) tick();
    endtask

    task automatic full_reset(int d);
        rin[d] = 1'b0;
        for (int i = 0; i < stg(d); i++)
            send(d, 4'd0, {$urandom, $urandom}, 64'd7, 6'(50 + i));
        @(negedge clk);
        check($sformatf("s%0d full_count", stg(d)), 64'(cnt[d]), 64'(stg(d)));
        check($sformatf("s%0d full_ready", stg(d)), 64'(ordy[d]), 64'd0);
        tick();
        rst_n[d] = 1'b0;
        tick();
        rst_n[d] = 1'b1;
        chk_reset_state(d, $sformatf("s%0d midrst", stg(d)));
        rin[d] = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            idle(d);
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        for (int d = 0; d < 3; d++) begin
            chk_reset_state(d, $sformatf("s%0d reset", stg(d)));
            directed(d, "add_wrap", 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd5, 64'd0);
            directed(d, "sub_wrap", 4'd1, 64'd0, 64'd1, 6'd9, 64'hFFFF_FFFF_FFFF_FFFF);
            directed(d, "sll_mask", 4'd5, 64'd1, 64'h41, 6'd1, 64'd2);
            directed(d, "sra63", 4'd7, 64'h8000_0000_0000_0000, 64'd63, 6'd2, 64'hFFFF_FFFF_FFFF_FFFF);
            directed(d, "srl63", 4'd6, 64'h8000_0000_0000_0000, 64'd63, 6'd3, 64'd1);
            directed(d, "slt_neg", 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd4, 64'd1);
            directed(d, "sltu_neg", 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd6, 64'd0);
            directed(d, "slt_eq", 4'd8, 64'd5, 64'd5, 6'd7, 64'd0);
            directed(d, "op12", 4'd12, 64'd7, 64'd9, 6'd12, 64'd0);
            stream10(d);
            if (stg(d) >= 2) flush_test(d);
            soak(d);
            full_reset(d);
            idle(d);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
